// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rx_pkg
// Description : Shared constants, FSM state type and the FIFO word packer used
//               by the receiver-to-sample-FIFO arbiter.
//               FIFO word layout:
//                 [31:28] channel tag
//                 [27:25] zero
//                 [24]    0 = I word, 1 = Q word
//                 [23:0]  sign-extended sample
// Revision    : 1.0  initial release
// ============================================================================
package rx_pkg;

    localparam int TAG_MSB  = 31;
    localparam int TAG_LSB  = 28;
    localparam int IQ_BIT   = 24;
    localparam int SAMPLE_W = 24;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_I = 2'd1,
        WR_Q = 2'd2
    } state_t;

    // Build one tagged FIFO word; every bit not named here stays zero.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [3:0]          chan,
        input logic                iq,
        input logic [SAMPLE_W-1:0] sample
    );
        logic [WORD_W-1:0] w;
        w                  = '0;
        w[TAG_MSB:TAG_LSB] = chan;
        w[IQ_BIT]          = iq;
        w[SAMPLE_W-1:0]    = sample;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Searches the request
//               vector starting one position after i_last_grant (wrapping
//               modulo N) and returns the first requesting index.
// Ports       : i_req         N   request per channel
//               i_last_grant  IW  most recently granted index
//               o_grant_idx   IW  selected index (0 when nothing requests)
//               o_grant_valid 1   at least one request present
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [IW-1:0] i_last_grant,
    output logic      [IW-1:0] o_grant_idx,
    output logic               o_grant_valid
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_cand        = '0;
        // Offset 1..N so the last granted channel is considered last.
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(i_last_grant) + k) % N);
            if (!o_grant_valid && i_req[w_cand]) begin
                o_grant_idx   = w_cand;
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rx_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rx_fifo_arbiter
// Description : Shares the single sample-FIFO write port among NUM_RX receiver
//               channels. Each channel owns a one-pair buffer slot; pending
//               slots are served round-robin and each pair is emitted as two
//               tagged words, I then Q, never interleaved with another channel.
// Ports       : clk              sample clock
//               reset            synchronous, active-high
//               i_rx_enable      per-channel enable (already in clk domain)
//               i_rx_strobe      per-channel 1-cycle sample-valid pulse
//               i_rx_i / i_rx_q  packed samples, channel n at [n*DW +: DW]
//               i_fifo_full      FIFO almost-full (>= 2 words headroom left)
//               o_fifo_write     registered write strobe, 1 cycle per word
//               o_fifo_writedata tagged sample word
//               o_overflow_count saturating count of dropped pairs
//               i_overflow_clear zeroes the overflow count
//               o_busy           FSM active or any slot pending
// Revision    : 1.0  initial release
// ============================================================================
module rx_fifo_arbiter
    import rx_pkg::*;
#(
    parameter int NUM_RX = 4,
    parameter int DW     = 24,
    parameter int OVF_W  = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic [NUM_RX-1:0]    i_rx_enable,
    input  wire logic [NUM_RX-1:0]    i_rx_strobe,
    input  wire logic [NUM_RX*DW-1:0] i_rx_i,
    input  wire logic [NUM_RX*DW-1:0] i_rx_q,
    input  wire logic                 i_fifo_full,
    output logic                      o_fifo_write,
    output logic [WORD_W-1:0]         o_fifo_writedata,
    output logic [OVF_W-1:0]          o_overflow_count,
    input  wire logic                 i_overflow_clear,
    output logic                      o_busy
);

    localparam int            c_IW         = (NUM_RX > 1) ? $clog2(NUM_RX) : 1;
    localparam logic [c_IW-1:0] c_LAST_RESET = c_IW'(NUM_RX - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    // Holds the channel being served and, once back in IDLE, the last one
    // granted; reset to NUM_RX-1 so channel 0 wins the first arbitration.
    logic [c_IW-1:0]       r_grant;
    logic [c_IW-1:0]       w_arb_idx;
    logic                  w_arb_valid;
    logic                  w_grant_load;
    logic                  w_q_issue;

    logic [NUM_RX-1:0]     r_pending;
    logic [NUM_RX-1:0]     w_pending_nxt;
    logic [NUM_RX-1:0]     w_req;
    logic [NUM_RX-1:0]     w_stb_ok;
    logic [NUM_RX-1:0]     w_q_done;
    logic [NUM_RX-1:0]     w_granted;
    logic [NUM_RX-1:0]     w_capture;
    logic [NUM_RX-1:0]     w_drop;
    logic [DW-1:0]         r_slot_i [NUM_RX];
    logic [DW-1:0]         r_slot_q [NUM_RX];

    logic                  r_fifo_write;
    logic                  w_write_nxt;
    logic [WORD_W-1:0]     r_fifo_writedata;
    logic [WORD_W-1:0]     w_data_nxt;

    logic [OVF_W-1:0]      r_ovf;
    logic [OVF_W-1:0]      w_ovf_nxt;
    logic [OVF_W-1:0]      w_ovf_base;
    logic [OVF_W+3:0]      w_ovf_sum;
    logic [3:0]            w_drop_cnt;

    function automatic logic [SAMPLE_W-1:0] sext(input logic [DW-1:0] s);
        logic [SAMPLE_W-1:0] r;
        r         = {SAMPLE_W{s[DW-1]}};
        r[DW-1:0] = s;
        return r;
    endfunction

    assign w_req = r_pending & i_rx_enable;

    rr_arbiter #(
        .N (NUM_RX)
    ) u_rr (
        .i_req         (w_req),
        .i_last_grant  (r_grant),
        .o_grant_idx   (w_arb_idx),
        .o_grant_valid (w_arb_valid)
    );

    // ------------------------------------------------------------------
    // FSM next state and output word
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_write_nxt  = 1'b0;
        w_data_nxt   = r_fifo_writedata;
        w_grant_load = 1'b0;
        w_q_issue    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_grant_load = 1'b1;
                    w_state_nxt  = WR_I;
                end
            end
            WR_I: begin
                if (!i_fifo_full) begin
                    w_write_nxt = 1'b1;
                    w_data_nxt  = pack_word(4'(r_grant), 1'b0, sext(r_slot_i[r_grant]));
                    w_state_nxt = WR_Q;
                end
            end
            WR_Q: begin
                if (!i_fifo_full) begin
                    w_write_nxt = 1'b1;
                    w_data_nxt  = pack_word(4'(r_grant), 1'b1, sext(r_slot_q[r_grant]));
                    w_q_issue   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-channel slot bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        w_stb_ok      = '0;
        w_granted     = '0;
        w_q_done      = '0;
        w_capture     = '0;
        w_drop        = '0;
        w_pending_nxt = r_pending;
        for (int n = 0; n < NUM_RX; n++) begin
            w_stb_ok[n]  = i_rx_strobe[n] & i_rx_enable[n];
            w_granted[n] = (r_state != IDLE) && (r_grant == c_IW'(n));
            w_q_done[n]  = w_q_issue && (r_grant == c_IW'(n));
            // A slot whose Q word leaves this cycle is free again, so a
            // coincident strobe refills it rather than counting as a drop.
            w_capture[n] = w_stb_ok[n] & (~r_pending[n] | w_q_done[n]);
            w_drop[n]    = w_stb_ok[n] & r_pending[n] & ~w_q_done[n];
            if (w_capture[n]) begin
                w_pending_nxt[n] = 1'b1;
            end else if (w_q_done[n]) begin
                w_pending_nxt[n] = 1'b0;
            end else if (!i_rx_enable[n] && !w_granted[n]) begin
                // Disabled channels lose their buffered pair, but a pair
                // already granted is always finished so no orphan I appears.
                w_pending_nxt[n] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating overflow counter; clear and new drops combine as 0 + drops
    // ------------------------------------------------------------------
    always_comb begin
        w_drop_cnt = '0;
        for (int n = 0; n < NUM_RX; n++) begin
            w_drop_cnt = w_drop_cnt + {3'b000, w_drop[n]};
        end
        w_ovf_base = i_overflow_clear ? '0 : r_ovf;
        w_ovf_sum  = {4'b0000, w_ovf_base} + {{OVF_W{1'b0}}, w_drop_cnt};
        w_ovf_nxt  = (|w_ovf_sum[OVF_W+3:OVF_W]) ? '1 : w_ovf_sum[OVF_W-1:0];
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_grant          <= c_LAST_RESET;
            r_pending        <= '0;
            r_fifo_write     <= 1'b0;
            r_fifo_writedata <= '0;
            r_ovf            <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_pending        <= w_pending_nxt;
            r_fifo_write     <= w_write_nxt;
            r_fifo_writedata <= w_data_nxt;
            r_ovf            <= w_ovf_nxt;
            if (w_grant_load) begin
                r_grant <= w_arb_idx;
            end
        end
    end

    // Sample slots are qualified by r_pending, so they need no reset.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NUM_RX; n++) begin
            if (w_capture[n]) begin
                r_slot_i[n] <= i_rx_i[n*DW +: DW];
                r_slot_q[n] <= i_rx_q[n*DW +: DW];
            end
        end
    end

    assign o_fifo_write     = r_fifo_write;
    assign o_fifo_writedata = r_fifo_writedata;
    assign o_overflow_count = r_ovf;
    assign o_busy           = (r_state != IDLE) || (|r_pending);

endmodule

`default_nettype wire

// File: tb/tb_rx_fifo_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rx_fifo_arbiter
// Description : Directed self-checking bench. u_dut uses default parameters;
//               u_dut_s (DW=16, OVF_W=4) covers sign extension and counter
//               saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rx_fifo_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rx_enable;
    logic [3:0]  rx_strobe;
    logic [95:0] rx_i;
    logic [95:0] rx_q;
    logic        fifo_full;
    logic        fifo_write;
    logic [31:0] fifo_writedata;
    logic [15:0] overflow_count;
    logic        overflow_clear;
    logic        busy;

    logic        s_reset;
    logic [3:0]  s_en;
    logic [3:0]  s_stb;
    logic [63:0] s_i;
    logic [63:0] s_q;
    logic        s_full;
    logic        s_wr;
    logic [31:0] s_wd;
    logic [3:0]  s_ovf;
    logic        s_clr;
    logic        s_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rx_fifo_arbiter u_dut (
        .clk              (clk),
        .reset            (reset),
        .i_rx_enable      (rx_enable),
        .i_rx_strobe      (rx_strobe),
        .i_rx_i           (rx_i),
        .i_rx_q           (rx_q),
        .i_fifo_full      (fifo_full),
        .o_fifo_write     (fifo_write),
        .o_fifo_writedata (fifo_writedata),
        .o_overflow_count (overflow_count),
        .i_overflow_clear (overflow_clear),
        .o_busy           (busy)
    );

    rx_fifo_arbiter #(
        .NUM_RX (4),
        .DW     (16),
        .OVF_W  (4)
    ) u_dut_s (
        .clk              (clk),
        .reset            (s_reset),
        .i_rx_enable      (s_en),
        .i_rx_strobe      (s_stb),
        .i_rx_i           (s_i),
        .i_rx_q           (s_q),
        .i_fifo_full      (s_full),
        .o_fifo_write     (s_wr),
        .o_fifo_writedata (s_wd),
        .o_overflow_count (s_ovf),
        .i_overflow_clear (s_clr),
        .o_busy           (s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [23:0] iv, input logic [23:0] qv);
        rx_i[ch*24 +: 24] = iv;
        rx_q[ch*24 +: 24] = qv;
    endtask

    // Expected round-robin word k: channel k/2, I (even k) or Q (odd k).
    function automatic logic [31:0] exp_rr(input int k);
        logic [23:0] s;
        s = (k % 2 == 1) ? (24'h200000 + 24'(k / 2)) : (24'h100000 + 24'(k / 2));
        return {4'(k / 2), 3'b000, 1'(k % 2), s};
    endfunction

    initial begin
        int k;

        // ---------------- reset ----------------
        reset = 1'b1; s_reset = 1'b1;
        rx_enable = '0; rx_strobe = '0; rx_i = '0; rx_q = '0;
        fifo_full = 1'b0; overflow_clear = 1'b0;
        s_en = '0; s_stb = '0; s_i = '0; s_q = '0; s_full = 1'b0; s_clr = 1'b0;
        tick(); tick();
        chk("rst_write", {31'd0, fifo_write}, 32'd0);
        chk("rst_data",  fifo_writedata, 32'd0);
        chk("rst_ovf",   {16'd0, overflow_count}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        reset = 1'b0; s_reset = 1'b0;
        tick();

        // ---------------- 1: single channel ----------------
        rx_enable = 4'b0001;
        set_ch(0, 24'h000123, 24'hFFFF00);
        rx_strobe = 4'b0001;
        tick();
        rx_strobe = '0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_wr_t1", {31'd0, fifo_write}, 32'd0);
        tick();
        chk("t1_wr_i", {31'd0, fifo_write}, 32'd1);
        chk("t1_i",    fifo_writedata, 32'h00000123);
        tick();
        chk("t1_wr_q", {31'd0, fifo_write}, 32'd1);
        chk("t1_q",    fifo_writedata, 32'h01FFFF00);
        tick();
        chk("t1_wr_end", {31'd0, fifo_write}, 32'd0);
        chk("t1_idle",   {31'd0, busy}, 32'd0);
        chk("t1_ovf",    {16'd0, overflow_count}, 32'd0);

        // ---------------- 2: round-robin ----------------
        reset = 1'b1; tick(); reset = 1'b0;
        rx_enable = 4'hF;
        for (int ch = 0; ch < 4; ch++) set_ch(ch, 24'h100000 + 24'(ch), 24'h200000 + 24'(ch));
        rx_strobe = 4'hF;
        tick();
        rx_strobe = '0;
        k = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("t2_wr_c%0d", c), {31'd0, fifo_write}, {31'd0, (c % 3) != 1});
            if (fifo_write === 1'b1 && k < 8) begin
                chk($sformatf("t2_word%0d", k), fifo_writedata, exp_rr(k));
                k++;
            end
        end
        chk("t2_count", k, 32'd8);

        // ---------------- 3: backpressure in WR_Q ----------------
        set_ch(0, 24'h0000C0, 24'h0000C1);
        rx_strobe = 4'b0001;
        tick();
        rx_strobe = '0;
        tick();
        tick();
        chk("t3_i", fifo_writedata, 32'h000000C0);
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("t3_hold%0d", c), {31'd0, fifo_write}, 32'd0);
        end
        fifo_full = 1'b0;
        tick();
        chk("t3_wr_q", {31'd0, fifo_write}, 32'd1);
        chk("t3_q",    fifo_writedata, 32'h010000C1);
        tick();
        chk("t3_nodup", {31'd0, fifo_write}, 32'd0);
        chk("t3_idle",  {31'd0, busy}, 32'd0);

        // ---------------- 4: overflow ----------------
        fifo_full = 1'b1;
        set_ch(1, 24'h0000A1, 24'h0000A2);
        rx_strobe = 4'b0010;
        tick();
        set_ch(1, 24'h0000B1, 24'h0000B2);
        tick();
        set_ch(1, 24'h0000C1, 24'h0000C2);
        tick();
        rx_strobe = '0;
        chk("t4_ovf2", {16'd0, overflow_count}, 32'd2);
        fifo_full = 1'b0;
        tick();
        chk("t4_first_i", fifo_writedata, 32'h100000A1);
        tick();
        chk("t4_first_q", fifo_writedata, 32'h110000A2);
        tick();
        chk("t4_wr_end", {31'd0, fifo_write}, 32'd0);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        chk("t4_clear", {16'd0, overflow_count}, 32'd0);
        // two channels drop together while clear is asserted -> 0 + 2
        fifo_full = 1'b1;
        set_ch(1, 24'h0000D1, 24'h0000D2);
        set_ch(2, 24'h0000E1, 24'h0000E2);
        rx_strobe = 4'b0110;
        tick();
        overflow_clear = 1'b1;
        tick();
        rx_strobe = '0;
        overflow_clear = 1'b0;
        chk("t4_clr_plus_drops", {16'd0, overflow_count}, 32'd2);
        fifo_full = 1'b0;
        for (int c = 0; c < 20 && busy === 1'b1; c++) tick();
        chk("t4_drained", {31'd0, busy}, 32'd0);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;

        // ---------------- 5: disable mid-transfer ----------------
        set_ch(2, 24'h0002A0, 24'h0002B0);
        set_ch(3, 24'h0003A0, 24'h0003B0);
        rx_strobe = 4'b1100;
        tick();
        rx_strobe = '0;
        tick();
        chk("t5_wr_i_state", {31'd0, fifo_write}, 32'd0);
        rx_enable = 4'b1011;
        tick();
        chk("t5_ch2_i", fifo_writedata, 32'h200002A0);
        tick();
        chk("t5_ch2_q_wr", {31'd0, fifo_write}, 32'd1);
        chk("t5_ch2_q",    fifo_writedata, 32'h210002B0);
        tick();
        chk("t5_gap", {31'd0, fifo_write}, 32'd0);
        tick();
        chk("t5_ch3_i", fifo_writedata, 32'h300003A0);
        tick();
        chk("t5_ch3_q", fifo_writedata, 32'h310003B0);
        tick();
        chk("t5_idle", {31'd0, busy}, 32'd0);
        rx_strobe = 4'b0100;
        tick();
        rx_strobe = '0;
        chk("t5_ign_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t5_ign_wr",  {31'd0, fifo_write}, 32'd0);
        chk("t5_ign_ovf", {16'd0, overflow_count}, 32'd0);

        // ---------------- 6: reset in WR_Q with FIFO full ----------------
        rx_enable = 4'hF;
        set_ch(2, 24'h0006A0, 24'h0006B0);
        rx_strobe = 4'b0100;
        tick();
        rx_strobe = '0;
        tick();
        tick();
        chk("t6_i", fifo_writedata, 32'h200006A0);
        fifo_full = 1'b1;
        set_ch(1, 24'h0007A0, 24'h0007B0);
        rx_strobe = 4'b0010;
        tick();
        rx_strobe = '0;
        tick();
        chk("t6_held", {31'd0, fifo_write}, 32'd0);
        reset = 1'b1;
        tick();
        chk("t6_rst_wr",   {31'd0, fifo_write}, 32'd0);
        chk("t6_rst_data", fifo_writedata, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        fifo_full = 1'b0;
        tick();
        chk("t6_no_q", {31'd0, fifo_write}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        set_ch(0, 24'h000600, 24'h000601);
        set_ch(1, 24'h000610, 24'h000611);
        rx_strobe = 4'b0011;
        tick();
        rx_strobe = '0;
        tick();
        tick();
        chk("t6_ch0_first", fifo_writedata, 32'h00000600);
        tick();
        chk("t6_ch0_q", fifo_writedata, 32'h01000601);
        tick();
        tick();
        chk("t6_ch1_i", fifo_writedata, 32'h10000610);
        tick();
        tick();
        chk("t6_done", {31'd0, busy}, 32'd0);

        // ---------------- DW=16 sign extension, OVF_W=4 saturation ----------------
        s_en = 4'b0001;
        s_i[15:0] = 16'h8000;
        s_q[15:0] = 16'h7FFF;
        s_stb = 4'b0001;
        tick();
        s_stb = '0;
        tick();
        tick();
        chk("s_wr_i", {31'd0, s_wr}, 32'd1);
        chk("s_i_sext", s_wd, 32'h00FF8000);
        tick();
        chk("s_q_sext", s_wd, 32'h01007FFF);
        tick();
        s_full = 1'b1;
        s_stb = 4'b0001;
        repeat (16) tick();
        chk("s_ovf15", {28'd0, s_ovf}, 32'd15);
        repeat (5) tick();
        s_stb = '0;
        chk("s_ovf_sat", {28'd0, s_ovf}, 32'd15);
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        chk("s_ovf_clr", {28'd0, s_ovf}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
